cbf_scan_scheduler: RTL

Time-multiplexes one conventional-beamformer power datapath across NUM_ANGLES steering vectors to produce a DOA spatial spectrum. Captures a block of SNAPSHOT_COUNT 4-channel I/Q snapshots into a local buffer, then replays the block once per angle against a runtime-configurable steering-coefficient table. Accumulates the returned momentary power per angle, streams one spectrum bin per angle, and reports the peak angle. Sits between the ADC/DDC snapshot stream and the downstream spectrum/peak consumer.

---
 rtl/cbf_pkg.sv | 33 +++
 rtl/cbf_coef_table.sv | 35 +++
 rtl/cbf_scan_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cbf_pkg.sv
// Shared constants and FSM encoding for the conventional-beamformer scan scheduler.
package cbf_pkg;

  localparam int unsigned CbfWordLengthIQ = 16;
  // Snapshot / steering words pack Ix1,Qx1..Ix4,Qx4, LSB first.
  localparam int unsigned CbfLanes = 8;

  localparam int unsigned LaneI1 = 0;
  localparam int unsigned LaneQ1 = 1;
  localparam int unsigned LaneI2 = 2;
  localparam int unsigned LaneQ2 = 3;
  localparam int unsigned LaneI3 = 4;
  localparam int unsigned LaneQ3 = 5;
  localparam int unsigned LaneI4 = 6;
  localparam int unsigned LaneQ4 = 7;

  function automatic int unsigned lane_lsb(int unsigned lane, int unsigned wiq);
    return lane * wiq;
  endfunction

  function automatic int unsigned power_momentary_width(int unsigned wiq);
    return ((wiq * 2) + 8) * 2;
  endfunction

  typedef enum logic [2:0] {
    StFill,
    StIssue,
    StWait,
    StEmit,
    StDone
  } state_e;

endpackage

// File: rtl/cbf_coef_table.sv
// Steering-coefficient table: one write port, one registered read port.
// A read and write to the same address on the same edge returns the old contents.
module cbf_coef_table #(
  parameter int unsigned Depth = 32,
  parameter int unsigned Width = 128,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic             re,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cbf_scan_scheduler.sv
// Replays a captured snapshot block once per steering angle through a shared power
// datapath, accumulates per-angle power, streams the spectrum and reports the peak.
module cbf_scan_scheduler
  import cbf_pkg::*;
#(
  parameter int unsigned WORD_LENGTH_I_AND_Q         = CbfWordLengthIQ,
  parameter int unsigned WORD_LENGTH_IN              = WORD_LENGTH_I_AND_Q * CbfLanes,
  parameter int unsigned SNAPSHOT_COUNT              = 8,
  parameter int unsigned NUM_ANGLES                  = 32,
  parameter int unsigned WORD_LENGTH_POWER_MOMENTARY = power_momentary_width(WORD_LENGTH_I_AND_Q),
  parameter int unsigned WORD_LENGTH_POWER           = WORD_LENGTH_POWER_MOMENTARY +
                                                       $clog2(SNAPSHOT_COUNT),
  parameter int unsigned ANGLE_W                     = $clog2(NUM_ANGLES)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [WORD_LENGTH_IN-1:0]              s_axis_tdata,
  input  logic                                   s_axis_tvalid,
  output logic                                   s_axis_tready,
  input  logic                                   cfg_we,
  input  logic [ANGLE_W-1:0]                     cfg_addr,
  input  logic [WORD_LENGTH_IN-1:0]              cfg_wdata,
  output logic [WORD_LENGTH_IN-1:0]              dp_x,
  output logic [WORD_LENGTH_IN-1:0]              dp_w,
  output logic                                   dp_valid,
  output logic                                   dp_last,
  input  logic [WORD_LENGTH_POWER_MOMENTARY-1:0] dp_power,
  input  logic                                   dp_power_valid,
  input  logic                                   dp_power_last,
  output logic [WORD_LENGTH_POWER-1:0]           m_axis_tdata,
  output logic [ANGLE_W-1:0]                     m_axis_tuser,
  output logic                                   m_axis_tlast,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic [ANGLE_W-1:0]                     peak_index,
  output logic [WORD_LENGTH_POWER-1:0]           peak_power,
  output logic                                   peak_valid,
  output logic                                   busy
);

  localparam int unsigned SW = $clog2(SNAPSHOT_COUNT);
  localparam logic [SW-1:0]      SnapLast  = SW'(SNAPSHOT_COUNT - 1);
  localparam logic [ANGLE_W-1:0] AngleLast = ANGLE_W'(NUM_ANGLES - 1);

  state_e state_q, state_d;
  logic                         run_q;
  logic [SW-1:0]                wr_cnt_q, s_cnt_q;
  logic [ANGLE_W-1:0]           angle_q;
  logic [WORD_LENGTH_IN-1:0]    snap_buf [SNAPSHOT_COUNT];
  logic [WORD_LENGTH_IN-1:0]    x_hold_q, coef_rdata;
  logic [WORD_LENGTH_POWER-1:0] acc_q, peak_power_q;
  logic [ANGLE_W-1:0]           peak_index_q, coef_raddr;
  logic                         s_fire, m_fire, res_fire, issue_entry;

  assign s_fire      = s_axis_tvalid && s_axis_tready;
  assign m_fire      = m_axis_tvalid && m_axis_tready;
  assign res_fire    = dp_power_valid && (state_q == StIssue || state_q == StWait);
  assign issue_entry = (state_d == StIssue) && (state_q != StIssue);
  assign coef_raddr  = (state_q == StFill) ? '0 : angle_q + ANGLE_W'(1);

  // The registered read output doubles as the per-angle steering latch.
  cbf_coef_table #(
    .Depth (NUM_ANGLES),
    .Width (WORD_LENGTH_IN)
  ) u_coef_table (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .re    (issue_entry),
    .raddr (coef_raddr),
    .rdata (coef_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StFill;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:  if (s_fire && wr_cnt_q == SnapLast) state_d = StIssue;
      StIssue: if (s_cnt_q == SnapLast) state_d = (res_fire && dp_power_last) ? StEmit : StWait;
      StWait:  if (res_fire && dp_power_last) state_d = StEmit;
      StEmit:  if (m_fire) state_d = (angle_q == AngleLast) ? StDone : StIssue;
      StDone:  state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  always_comb begin
    s_axis_tready = run_q && (state_q == StFill);
    busy          = (state_q != StFill);
    dp_valid      = (state_q == StIssue);
    dp_last       = dp_valid && (s_cnt_q == SnapLast);
    dp_x          = dp_valid ? snap_buf[s_cnt_q] : x_hold_q;
    dp_w          = coef_rdata;
    m_axis_tvalid = (state_q == StEmit);
    m_axis_tdata  = acc_q;
    m_axis_tuser  = angle_q;
    m_axis_tlast  = (state_q == StEmit) && (angle_q == AngleLast);
    peak_valid    = (state_q == StDone);
    peak_index    = peak_index_q;
    peak_power    = peak_power_q;
  end

  always_ff @(posedge clk) begin
    if (s_fire) snap_buf[wr_cnt_q] <= s_axis_tdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q        <= 1'b0;
      wr_cnt_q     <= '0;
      s_cnt_q      <= '0;
      angle_q      <= '0;
      x_hold_q     <= '0;
      acc_q        <= '0;
      peak_index_q <= '0;
      peak_power_q <= '0;
    end else begin
      run_q <= 1'b1;
      if (state_q == StDone)  wr_cnt_q <= '0;
      else if (s_fire)        wr_cnt_q <= wr_cnt_q + 1'b1;
      // Snapshot index wraps back to 0 after the last issue of each angle.
      if (dp_valid) begin
        s_cnt_q  <= s_cnt_q + 1'b1;
        x_hold_q <= snap_buf[s_cnt_q];
      end
      if (issue_entry)   acc_q <= '0;
      else if (res_fire) acc_q <= acc_q + WORD_LENGTH_POWER'(dp_power);
      if (state_q == StFill && issue_entry) angle_q <= '0;
      else if (m_fire && issue_entry)       angle_q <= angle_q + ANGLE_W'(1);
      // Strict compare keeps the lowest index on ties.
      if (m_fire && (angle_q == '0 || acc_q > peak_power_q)) begin
        peak_index_q <= angle_q;
        peak_power_q <= acc_q;
      end
    end
  end

endmodule
